// File: rtl/delay_line.sv
// Programmable-tap delay line: MAX_DEPTH shift stages with per-stage valid bits,
// a runtime-selected output tap and a saturating fill counter that drives primed.
module delay_line #(
    parameter int D_WIDTH   = 8,
    parameter int MAX_DEPTH = 16,
    localparam int SEL_W    = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               flush,
    input  logic [D_WIDTH-1:0] Din,
    input  logic               din_valid,
    input  logic [SEL_W-1:0]   delay_sel,
    output logic [D_WIDTH-1:0] Dout,
    output logic               dout_valid,
    output logic               primed
);

    localparam int IDX_W = $clog2(MAX_DEPTH);
    localparam logic [SEL_W-1:0] MAX_D = SEL_W'(MAX_DEPTH);

    // din_valid is not a handshake: it is a tag that travels with its sample,
    // and dout_valid is simply that tag read back from the selected tap.
    logic [D_WIDTH-1:0] stage [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] vld;
    logic [SEL_W-1:0]     fill_cnt;
    logic [SEL_W-1:0]     eff_d;
    logic [IDX_W-1:0]     tap;

    always_comb begin
        eff_d = delay_sel;
        if (delay_sel == '0) begin
            eff_d = SEL_W'(1);
        end else if (delay_sel > MAX_D) begin
            eff_d = MAX_D;
        end
        tap = IDX_W'(eff_d - SEL_W'(1));
    end

    // Flush wins over en: valid tracking restarts, stage data is left in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                stage[i] <= '0;
            end
            vld      <= '0;
            fill_cnt <= '0;
        end else if (flush) begin
            vld      <= '0;
            fill_cnt <= '0;
        end else if (en) begin
            stage[0] <= Din;
            for (int i = 1; i < MAX_DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
            vld <= {vld[MAX_DEPTH-2:0], din_valid};
            if (fill_cnt != MAX_D) begin
                fill_cnt <= fill_cnt + SEL_W'(1);
            end
        end
    end

    assign Dout       = stage[tap];
    assign dout_valid = vld[tap];
    assign primed     = (fill_cnt >= eff_d);

endmodule

// File: tb/tb_delay_line.sv
// Bench for delay_line: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a history-queue model.
module tb_delay_line;

    localparam int D_WIDTH   = 8;
    localparam int MAX_DEPTH = 16;
    localparam int SEL_W     = $clog2(MAX_DEPTH + 1);

    logic               clk = 1'b0;
    logic               reset_n;
    logic               en;
    logic               flush;
    logic [D_WIDTH-1:0] Din;
    logic               din_valid;
    logic [SEL_W-1:0]   delay_sel;
    logic [D_WIDTH-1:0] Dout;
    logic               dout_valid;
    logic               primed;

    int n_checks = 0;
    int n_errors = 0;

    // Model: every captured sample as {valid, data}, newest at index 0.
    logic [D_WIDTH:0] m_hist [$];
    int               m_fill;

    delay_line #(.D_WIDTH(D_WIDTH), .MAX_DEPTH(MAX_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .flush(flush),
        .Din(Din), .din_valid(din_valid), .delay_sel(delay_sel),
        .Dout(Dout), .dout_valid(dout_valid), .primed(primed)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic int eff_d(input logic [SEL_W-1:0] sel);
        if (sel == 0) return 1;
        if (int'(sel) > MAX_DEPTH) return MAX_DEPTH;
        return int'(sel);
    endfunction

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < MAX_DEPTH; i++) m_hist.push_back('0);
        m_fill = 0;
    endtask

    task automatic model_step();
        logic [D_WIDTH:0] e;
        if (!reset_n) begin
            model_reset();
        end else if (flush) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                e = m_hist[i];
                e[D_WIDTH] = 1'b0;
                m_hist[i] = e;
            end
            m_fill = 0;
        end else if (en) begin
            m_hist.push_front({din_valid, Din});
            void'(m_hist.pop_back());
            if (m_fill < MAX_DEPTH) m_fill++;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [D_WIDTH:0] e;
        int d;
        d = eff_d(delay_sel);
        e = m_hist[d-1];
        chk("cyc_dout",   32'(Dout),       32'(e[D_WIDTH-1:0]));
        chk("cyc_valid",  32'(dout_valid), 32'(e[D_WIDTH]));
        chk("cyc_primed", 32'(primed),     32'(m_fill >= d));
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic e, input logic f, input logic [D_WIDTH-1:0] d, input logic v);
        en = e; flush = f; Din = d; din_valid = v;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic async_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_dout",   32'(Dout),       32'h0);
        chk("rst_valid",  32'(dout_valid), 32'h0);
        chk("rst_primed", 32'(primed),     32'h0);
        cyc(1'b1, 1'b0, 8'hEE, 1'b1);
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        reset_n = 1'b0; en = 1'b0; flush = 1'b0; Din = '0; din_valid = 1'b0; delay_sel = 5'd4;
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("init_dout",   32'(Dout),       32'h0);
        chk("init_primed", 32'(primed),     32'h0);
        reset_n = 1'b1;

        // Latency at delay 4 from reset release.
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 1'b0, 8'(k), 1'b1);
            if (k == 3) begin
                chk("lat4_primed_early", 32'(primed),     32'h0);
                chk("lat4_valid_early",  32'(dout_valid), 32'h0);
            end
            if (k >= 4) begin
                chk("lat4_dout",   32'(Dout),       32'(k - 3));
                chk("lat4_valid",  32'(dout_valid), 32'h1);
                chk("lat4_primed", 32'(primed),     32'h1);
            end
        end

        // Idle edges do not count toward latency.
        async_reset();
        delay_sel = 5'd3;
        cyc(1'b1, 1'b0, 8'hA5, 1'b1);
        cyc(1'b0, 1'b0, 8'h11, 1'b1);
        chk("idle_dout_hold", 32'(Dout), 32'h0);
        cyc(1'b1, 1'b0, 8'h22, 1'b1);
        cyc(1'b0, 1'b0, 8'h33, 1'b1);
        chk("idle_valid_early", 32'(dout_valid), 32'h0);
        cyc(1'b1, 1'b0, 8'h44, 1'b1);
        chk("idle_dout", 32'(Dout),       32'hA5);
        chk("idle_valid", 32'(dout_valid), 32'h1);

        // Shrink delay at steady state.
        async_reset();
        delay_sel = 5'd8;
        for (int k = 1; k <= 20; k++) cyc(1'b1, 1'b0, 8'(k), 1'b1);
        chk("sel8_dout", 32'(Dout), 32'd13);
        delay_sel = 5'd2;
        #1;
        chk("sel2_dout",   32'(Dout),   32'd19);
        chk("sel2_primed", 32'(primed), 32'h1);

        // Grow delay beyond fill.
        async_reset();
        delay_sel = 5'd2;
        for (int k = 1; k <= 5; k++) cyc(1'b1, 1'b0, 8'(k), 1'b1);
        chk("grow_pre_dout", 32'(Dout), 32'd4);
        delay_sel = 5'd16;
        #1;
        chk("grow_primed", 32'(primed),     32'h0);
        chk("grow_valid",  32'(dout_valid), 32'h0);
        for (int k = 6; k <= 16; k++) begin
            cyc(1'b1, 1'b0, 8'(k), 1'b1);
            if (k == 15) chk("grow_primed_15", 32'(primed), 32'h0);
        end
        chk("grow_primed_16", 32'(primed), 32'h1);
        chk("grow_dout_16",   32'(Dout),   32'd1);

        // Flush wins over en and restarts valid tracking.
        async_reset();
        delay_sel = 5'd4;
        for (int k = 1; k <= 10; k++) cyc(1'b1, 1'b0, 8'(k), 1'b1);
        cyc(1'b1, 1'b1, 8'h77, 1'b1);
        chk("flush_valid",  32'(dout_valid), 32'h0);
        chk("flush_primed", 32'(primed),     32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 8'(100 + k), 1'b1);
            if (k == 2) chk("flush_valid_early", 32'(dout_valid), 32'h0);
        end
        chk("flush_dout",  32'(Dout),       32'd100);
        chk("flush_valid_back", 32'(dout_valid), 32'h1);

        // Clamp of out-of-range selects, then async reset mid-stream.
        async_reset();
        delay_sel = 5'd0;
        for (int k = 1; k <= 3; k++) cyc(1'b1, 1'b0, 8'(k), 1'b1);
        chk("sel0_dout", 32'(Dout), 32'd3);
        delay_sel = 5'd31;
        for (int k = 4; k <= 16; k++) cyc(1'b1, 1'b0, 8'(k), 1'b1);
        chk("sel31_dout",   32'(Dout),   32'd1);
        chk("sel31_primed", 32'(primed), 32'h1);
        async_reset();

        // Randomized run.
        for (int n = 0; n < 3000; n++) begin
            delay_sel = SEL_W'($urandom_range(0, 31));
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0),
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 Parameter D_WIDTH, default 8: width of each data sample in bits.
REQ-002 Parameter MAX_DEPTH, default 16: number of storage stages, legal range 2..256.
REQ-003 Derived parameter SEL_W = $clog2(MAX_DEPTH+1): width of delay_sel.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 en  input  1  shift enable; the line advances only on edges where en=1.
REQ-007 flush  input  1  synchronous clear of valid tracking and fill count.
REQ-008 Din  input  D_WIDTH  input sample.
REQ-009 din_valid  input  1  qualifies Din; shifted alongside the data.
REQ-010 delay_sel  input  SEL_W  runtime delay in enabled shifts, 1..MAX_DEPTH.
REQ-011 Dout  output  D_WIDTH  sample at the selected tap.
REQ-012 dout_valid  output  1  valid bit accompanying Dout.
REQ-013 primed  output  1  high when at least the selected delay's worth of shifts has occurred since reset or flush.

Function
REQ-014 The block SHALL hold MAX_DEPTH data stages stage[0..MAX_DEPTH-1], each with a companion valid bit vld[i].
REQ-015 On a rising edge with en=1 and flush=0, stage[0]<=Din and vld[0]<=din_valid; for i>=1, stage[i]<=stage[i-1] and vld[i]<=vld[i-1].
REQ-016 On an edge with en=0 and flush=0, all stages, valid bits and fill count SHALL hold.
REQ-017 Effective delay d SHALL be delay_sel clamped: 0 maps to 1, and values above MAX_DEPTH map to MAX_DEPTH.
REQ-018 Dout=stage[d-1] and dout_valid=vld[d-1], both selected combinationally from registered stages with no added register stage.
REQ-019 Latency: a sample captured on enabled edge k SHALL appear on Dout immediately after enabled edge k+d-1, i.e. after d enabled edges counting edge k.
REQ-020 Idle edges (en=0) SHALL not count toward latency.
REQ-021 fill_cnt (internal, width SEL_W) SHALL increment on each enabled, non-flush edge and saturate at MAX_DEPTH.
REQ-022 primed SHALL be (fill_cnt >= d), evaluated combinationally.
REQ-023 A flush=1 edge SHALL clear all vld[i] and fill_cnt to 0 and SHALL not capture Din, regardless of en.
REQ-024 Stage data is not required to clear on flush; only dout_valid and primed are guaranteed low afterwards.
REQ-025 A change of delay_sel SHALL take effect in the same cycle: Dout and dout_valid switch to the new tap, and no history is lost or reordered.
REQ-026 When delay_sel decreases, primed SHALL reflect the new d immediately; when delay_sel increases, primed SHALL drop if fill_cnt < new d.
REQ-027 With MAX_DEPTH=d and en held at 1, the behaviour SHALL equal a plain fixed shift register of depth d.

Reset
REQ-028 While reset_n=0, all stage[i]=0, all vld[i]=0 and fill_cnt=0, asynchronously, independent of clk.
REQ-029 Therefore during reset Dout=0, dout_valid=0 and primed=0.
REQ-030 Reset release SHALL be synchronous to clk externally; the first enabled edge after release SHALL capture Din normally.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight samples; no sample captured before reset may reappear.

Verification
REQ-032 MAX_DEPTH=16, delay_sel=4, en=1, Din=1,2,3,... with din_valid=1 from reset release -> Dout=1 and dout_valid=1 immediately after the 4th edge; primed rises in the same cycle; each following value appears one edge later.
REQ-033 delay_sel=3, en pattern 1,0,1,0,1 with Din=0xA5 on the first enabled edge -> Dout=0xA5 only after the 3rd enabled edge (the 5th clock); no change on the idle edges.
REQ-034 Stream 1..20 at delay_sel=8, then switch to delay_sel=2 at steady state -> Dout jumps to the sample two shifts old in the same cycle; primed stays 1.
REQ-035 Switch delay_sel from 2 to 16 after 5 shifts -> primed=0 and dout_valid=0 until fill_cnt reaches 16.
REQ-036 flush=1 with en=1 after 10 shifts at delay_sel=4 -> next cycle dout_valid=0 and primed=0; Din on the flush edge is not captured; valid output resumes 4 enabled edges later.
REQ-037 delay_sel=0 and delay_sel=31 with MAX_DEPTH=16 -> behaviour identical to delay_sel=1 and delay_sel=16 respectively; async reset pulse mid-stream -> outputs 0 with no clock edge.
